tx_fifo_buffer: RTL

// - Storage and read side of the 6-entry TX FIFO; sits directly downstream of the head-pointer counter.
// - Takes the write index and wrap toggle (head_ptr/head_tog) from that counter and owns the tail (read) pointer.
// - Stores write data at head_ptr and drives the counter's count enable (wr_accept) only when not full.
// - Produces empty/full/occupancy and registered read data for the TX encoder.

---
 rtl/tx_fifo_buffer.sv | 105 ++++++++++
 1 files changed

// File: rtl/tx_fifo_buffer.sv
// Storage and read side of the 6-entry TX FIFO; head pointer comes from the head counter.
// Optional sticky overflow/underflow flags enabled by defining TX_FIFO_ERR_EN.
module tx_fifo_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int LAST_IDX   = 5
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_WIDTH-1:0]  head_ptr,
    input  logic                  head_tog,
    output logic                  wr_accept,
    input  logic                  rd_req,
    output logic                  rd_accept,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  empty,
    output logic                  full,
    output logic [2:0]            count
`ifdef TX_FIFO_ERR_EN
    ,
    output logic                  ovf_err,
    output logic                  unf_err
`endif
);

    localparam int DEPTH = LAST_IDX + 1;
    localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(LAST_IDX);
    localparam logic [PTR_WIDTH:0]   DEPTH_W = (PTR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  tail_ptr;
    logic                  tail_tog;
    logic                  ptr_eq;
    logic [PTR_WIDTH:0]    diff;

    assign ptr_eq    = (head_ptr == tail_ptr);
    assign empty     = ptr_eq & (head_tog == tail_tog);
    assign full      = ptr_eq & (head_tog != tail_tog);
    assign wr_accept = wr_req & ~full;
    assign rd_accept = rd_req & ~empty;

    // Pointer distance modulo the non-power-of-two depth
    always_comb begin
        diff = '0;
        if (head_ptr > tail_ptr)
            diff = {1'b0, head_ptr} - {1'b0, tail_ptr};
        else
            diff = {1'b0, head_ptr} + DEPTH_W - {1'b0, tail_ptr};
    end

    always_comb begin
        count = diff[2:0];
        if (empty)
            count = 3'd0;
        else if (full)
            count = 3'(DEPTH);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_accept) begin
            mem[head_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tail_ptr <= '0;
            tail_tog <= 1'b0;
            rdata    <= '0;
            rvalid   <= 1'b0;
        end else begin
            rvalid <= rd_accept;
            if (rd_accept) begin
                rdata <= mem[tail_ptr];
                if (tail_ptr == LAST) begin
                    tail_ptr <= '0;
                    tail_tog <= ~tail_tog;
                end else begin
                    tail_ptr <= tail_ptr + 1'b1;
                end
            end
        end
    end

`ifdef TX_FIFO_ERR_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (wr_req & full)
                ovf_err <= 1'b1;
            if (rd_req & empty)
                unf_err <= 1'b1;
        end
    end
`endif

endmodule
